// File: rtl/uart_tx_pkg.sv
// Shared types, defaults and CRC-8 helper for the UART frame transmitter.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam int         DEF_BAUD_DIV = 5208;
    localparam logic [7:0] DEF_CRC_POLY = 8'h07;
    localparam logic [7:0] DEF_CRC_INIT = 8'h00;

    // Bit-serial CRC-8: feeds the low nbits of word MSB-first, no reflection, no final XOR.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] word,
                                             input logic [7:0] poly, input int nbits);
        logic [7:0] c;
        logic       fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (i < nbits) begin
                fb = c[7] ^ word[i];
                c  = {c[6:0], 1'b0} ^ (fb ? poly : 8'h00);
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous word FIFO with occupancy count; count separates full from empty
// since pointers wrap modulo DEPTH (DEPTH must be a power of two).
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; contents are only visible through count.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/uart_frame_transmitter.sv
// Buffered UART transmitter with running CRC-8 and a CRC trailer frame on finish.
// Optional parity bit per frame when UART_TX_PARITY_EN is defined.
module uart_frame_transmitter
    import uart_tx_pkg::*;
#(
    parameter int         BAUD_DIV   = DEF_BAUD_DIV,
    parameter int         DATA_BITS  = 8,
    parameter int         FIFO_DEPTH = 16,
    parameter int         STOP_BITS  = 1,
    parameter logic [7:0] CRC_POLY   = DEF_CRC_POLY,
    parameter logic [7:0] CRC_INIT   = DEF_CRC_INIT,
    parameter int         PARITY_ODD = 0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          din,
    input  logic                          din_valid,
    output logic                          din_ready,
    input  logic                          finish,
    input  logic                          hold,
    output logic                          tx,
    output logic                          busy,
    output logic                          acknowledge,
    output logic [7:0]                    crc,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    // state  | meaning
    // IDLE   | line high; pop a word or start the trailer unless hold
    // START  | start bit (low)
    // DATA   | DATA_BITS data bits, LSB first
    // PARITY | parity bit (only with UART_TX_PARITY_EN)
    // STOP   | STOP_BITS stop bits (high); trailer completion pulses acknowledge

    localparam int CNT_W = (STOP_BITS * BAUD_DIV > 1) ? $clog2(STOP_BITS * BAUD_DIV) : 1;
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] STOP_RELOAD = CNT_W'(STOP_BITS * BAUD_DIV - 1);

    if (BAUD_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 8 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_param_err
        $error("uart_frame_transmitter: illegal parameter set");
    end

    tx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [7:0]           crc_q, crc_d;
    logic                 pend_q, pend_d;
    logic                 trailer_q, trailer_d;
    logic                 ack_q, ack_d;
    logic                 tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    logic                 fifo_pop, fifo_push, fifo_full, fifo_empty;
    logic [DATA_BITS-1:0] fifo_rd_data;

    assign din_ready   = !fifo_full && !pend_q;
    assign fifo_push   = din_valid && din_ready;
    assign busy        = (state_q != IDLE) || !fifo_empty || pend_q;
    assign tx          = tx_q;
    assign acknowledge = ack_q;
    assign crc         = crc_q;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (fifo_push),
        .wr_data (din),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        crc_d     = crc_q;
        pend_d    = pend_q | finish;
        trailer_d = trailer_q;
        ack_d     = 1'b0;
        fifo_pop  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (!hold && !fifo_empty) begin
                    fifo_pop  = 1'b1;
                    crc_d     = crc8_step(crc_q, 8'(fifo_rd_data), CRC_POLY, DATA_BITS);
                    shift_d   = fifo_rd_data;
                    trailer_d = 1'b0;
                    state_d   = START;
                    cnt_d     = BIT_RELOAD;
                end else if (!hold && pend_q) begin
                    shift_d   = crc_q[DATA_BITS-1:0];
                    trailer_d = 1'b1;
                    state_d   = START;
                    cnt_d     = BIT_RELOAD;
                end
`ifdef UART_TX_PARITY_EN
                parity_d = (^shift_d) ^ (PARITY_ODD != 0);
`endif
            end
            START: begin
                if (cnt_q == '0) begin
                    state_d = DATA;
                    cnt_d   = BIT_RELOAD;
                    bit_d   = BIT_W'(DATA_BITS - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    if (bit_q == '0) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        cnt_d   = BIT_RELOAD;
`else
                        state_d = STOP;
                        cnt_d   = STOP_RELOAD;
`endif
                    end else begin
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q - BIT_W'(1);
                        cnt_d   = BIT_RELOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            PARITY: begin
                if (cnt_q == '0) begin
                    state_d = STOP;
                    cnt_d   = STOP_RELOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    if (trailer_q) begin
                        ack_d     = 1'b1;
                        crc_d     = CRC_INIT;
                        pend_d    = 1'b0;
                        trailer_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // tx is registered from next-state values so the pin never glitches on decode.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            crc_q     <= CRC_INIT;
            pend_q    <= 1'b0;
            trailer_q <= 1'b0;
            ack_q     <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            crc_q     <= crc_d;
            pend_q    <= pend_d;
            trailer_q <= trailer_d;
            ack_q     <= ack_d;
            tx_q      <= tx_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) parity_q <= 1'b0;
        else       parity_q <= parity_d;
    end
`endif

endmodule
